fetch_unit: RTL and testbench

- Instruction-fetch stage that drives the 8-bit program counter into the combinational instruction memory.
- Registers the returned 19-bit instruction, together with its PC, into an IF/ID register for the decoder.
- Handles downstream stall, branch/jump redirect with a one-bubble flush, and HALT detection.
- Keeps a saturating count of instructions issued.

---
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the PC into a combinational instruction
// memory and registers the returned word with its PC into the IF/ID register.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   stall                  downstream not ready; hold PC and IF/ID
//   redirect_valid/_target taken branch/jump from execute (wins over stall)
//   pc_out                 PC register, memory read address
//   instr_in               memory read data for pc_out (same cycle)
//   if_valid/if_instr/if_pc  IF/ID register
//   halted                 fetch stopped on a HALT instruction
//   fetch_count            saturating count of issued instructions
module fetch_unit #(
   parameter logic [7:0]  RESET_PC    = 8'd0,
   parameter logic [4:0]  HALT_OPCODE = 5'b11111,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [7:0]       redirect_target,
   output logic [7:0]       pc_out,
   input  logic [18:0]      instr_in,
   output logic             if_valid,
   output logic [18:0]      if_instr,
   output logic [7:0]       if_pc,
   output logic             halted,
   output logic [CNT_W-1:0] fetch_count
);

   typedef enum logic {
      S_RUN,
      S_HALTED
   } state_e;

   state_e state_q, state_d;

   logic [7:0]       pc_q, pc_d;
   logic             vld_q, vld_d;
   logic [18:0]      instr_q, instr_d;
   logic [7:0]       ifpc_q, ifpc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic is_halt;
   logic run;
   logic do_redir;
   logic do_fetch;

   assign is_halt  = (instr_in[18:14] == HALT_OPCODE);
   assign run      = (state_q == S_RUN);
   assign do_redir = run && redirect_valid;
   assign do_fetch = run && !redirect_valid && !stall;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: a HALT only counts when it is actually issued,
   // so a redirect or stall in the same cycle leaves us in RUN.
   always_comb begin
      state_d = state_q;
      if (do_fetch && is_halt) begin
         state_d = S_HALTED;
      end
   end

   // Output logic
   always_comb begin
      halted = (state_q == S_HALTED);
   end

   // Datapath next-state
   always_comb begin
      pc_d    = pc_q;
      vld_d   = vld_q;
      instr_d = instr_q;
      ifpc_d  = ifpc_q;
      cnt_d   = cnt_q;
      unique case (1'b1)
         !run: begin
            // HALT stays presented until the consumer accepts it once
            if (!stall) begin
               vld_d = 1'b0;
            end
         end
         do_redir: begin
            pc_d  = redirect_target;
            vld_d = 1'b0;
         end
         do_fetch: begin
            instr_d = instr_in;
            ifpc_d  = pc_q;
            vld_d   = 1'b1;
            if (!(&cnt_q)) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (!is_halt) begin
               pc_d = pc_q + 8'd1;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         vld_q   <= 1'b0;
         instr_q <= 19'd0;
         ifpc_q  <= 8'd0;
         cnt_q   <= '0;
      end else begin
         pc_q    <= pc_d;
         vld_q   <= vld_d;
         instr_q <= instr_d;
         ifpc_q  <= ifpc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc_out      = pc_q;
   assign if_valid    = vld_q;
   assign if_instr    = instr_q;
   assign if_pc       = ifpc_q;
   assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: program-level model plus directed scenarios.
module tb_fetch_unit;

   localparam int CW   = 5;
   localparam int CMAX = (1 << CW) - 1;
   localparam logic [18:0] HALT = 19'h7C000;
   localparam logic [18:0] I0   = 19'b0101000000000001000;

   logic          clk;
   logic          rst_n;
   logic          stall;
   logic          redirect_valid;
   logic [7:0]    redirect_target;
   logic [7:0]    pc_out;
   logic [18:0]   instr_in;
   logic          if_valid;
   logic [18:0]   if_instr;
   logic [7:0]    if_pc;
   logic          halted;
   logic [CW-1:0] fetch_count;

   logic [18:0] mem [256];

   int n_chk;
   int n_pass;

   fetch_unit #(
      .RESET_PC   (8'd0),
      .HALT_OPCODE(5'b11111),
      .CNT_W      (CW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_target(redirect_target),
      .pc_out         (pc_out),
      .instr_in       (instr_in),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .halted         (halted),
      .fetch_count    (fetch_count)
   );

   assign instr_in = mem[pc_out];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (act === exp) begin
         n_pass = n_pass + 1;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   // Program-level model: what a fetch stage must present after each edge
   int          m_pc;
   bit          m_v;
   logic [18:0] m_instr;
   int          m_ifpc;
   bit          m_halt;
   int          m_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc    <= 0;
         m_v     <= 0;
         m_instr <= '0;
         m_ifpc  <= 0;
         m_halt  <= 0;
         m_cnt   <= 0;
      end else if (m_halt) begin
         if (!stall) m_v <= 0;
      end else if (redirect_valid) begin
         m_pc <= int'(redirect_target);
         m_v  <= 0;
      end else if (!stall) begin
         m_instr <= mem[m_pc];
         m_ifpc  <= m_pc;
         m_v     <= 1;
         m_cnt   <= (m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
         if (mem[m_pc] == HALT) m_halt <= 1;
         else m_pc <= (m_pc + 1) % 256;
      end
   end

   always @(negedge clk) begin
      chk("m_pc", 32'(pc_out), 32'(m_pc));
      chk("m_valid", 32'(if_valid), 32'(m_v));
      chk("m_halted", 32'(halted), 32'(m_halt));
      chk("m_count", 32'(fetch_count), 32'(m_cnt));
      if (m_v) begin
         chk("m_instr", 32'(if_instr), 32'(m_instr));
         chk("m_ifpc", 32'(if_pc), 32'(m_ifpc));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic fill_plain();
      for (int i = 0; i < 256; i++) begin
         mem[i] = {5'b00010, 6'd0, 8'(i)};
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc(2);
      chk("rst_pc", 32'(pc_out), 32'h0);
      chk("rst_valid", 32'(if_valid), 32'h0);
      rst_n = 1'b1;
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      stall = 0;
      redirect_valid = 0;
      redirect_target = 8'h00;
      mem[0] = I0;
      for (int i = 1; i < 256; i++) mem[i] = HALT;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;

      // Reset and HALT at address 1
      cyc(2);
      chk("rst_pc", 32'(pc_out), 32'h0);
      chk("rst_instr", 32'(if_instr), 32'h0);
      chk("rst_ifpc", 32'(if_pc), 32'h0);
      chk("rst_halt", 32'(halted), 32'h0);
      rst_n = 1'b1;
      cyc(1);
      chk("c1_instr", 32'(if_instr), 32'(I0));
      chk("c1_ifpc", 32'(if_pc), 32'h0);
      chk("c1_valid", 32'(if_valid), 32'h1);
      chk("c1_pc", 32'(pc_out), 32'h1);
      cyc(1);
      chk("c2_instr", 32'(if_instr), 32'(HALT));
      chk("c2_ifpc", 32'(if_pc), 32'h1);
      chk("c2_halt", 32'(halted), 32'h1);
      chk("c2_pc", 32'(pc_out), 32'h1);
      cyc(1);
      chk("c3_valid", 32'(if_valid), 32'h0);
      chk("c3_count", 32'(fetch_count), 32'h2);

      // Stall at pc=5
      fill_plain();
      do_reset();
      cyc(5);
      chk("st_pc0", 32'(pc_out), 32'h5);
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk("st_pc", 32'(pc_out), 32'h5);
         chk("st_ifpc", 32'(if_pc), 32'h4);
         chk("st_count", 32'(fetch_count), 32'h5);
      end
      stall = 0;
      cyc(1);
      chk("st_rel_pc", 32'(pc_out), 32'h6);
      chk("st_rel_ifpc", 32'(if_pc), 32'h5);

      // Redirect wins over stall at pc=3
      do_reset();
      cyc(3);
      chk("rd_pc0", 32'(pc_out), 32'h3);
      redirect_valid = 1;
      redirect_target = 8'h40;
      stall = 1;
      cyc(1);
      chk("rd_pc", 32'(pc_out), 32'h40);
      chk("rd_valid", 32'(if_valid), 32'h0);
      chk("rd_ifpc_hold", 32'(if_pc), 32'h2);
      redirect_valid = 0;
      stall = 0;
      cyc(1);
      chk("rd_ifpc", 32'(if_pc), 32'h40);
      chk("rd_valid2", 32'(if_valid), 32'h1);

      // PC wrap FE, FF, 00, 01
      redirect_valid = 1;
      redirect_target = 8'hFE;
      cyc(1);
      redirect_valid = 0;
      chk("wr_pc", 32'(pc_out), 32'hFE);
      cyc(1);
      chk("wr_fe", 32'(if_pc), 32'hFE);
      cyc(1);
      chk("wr_ff", 32'(if_pc), 32'hFF);
      cyc(1);
      chk("wr_00", 32'(if_pc), 32'h00);
      cyc(1);
      chk("wr_01", 32'(if_pc), 32'h01);
      chk("wr_halt", 32'(halted), 32'h0);

      // Count saturates at all-ones
      cyc(40);
      chk("sat_count", 32'(fetch_count), 32'(CMAX));

      // HALT under stall, redirect ignored while halted
      mem[8'h10] = HALT;
      redirect_valid = 1;
      redirect_target = 8'h10;
      cyc(1);
      redirect_valid = 0;
      chk("hs_pc", 32'(pc_out), 32'h10);
      cyc(1);
      chk("hs_halt", 32'(halted), 32'h1);
      chk("hs_instr", 32'(if_instr), 32'(HALT));
      stall = 1;
      for (int i = 0; i < 2; i++) begin
         cyc(1);
         chk("hs_valid", 32'(if_valid), 32'h1);
         chk("hs_ifpc", 32'(if_pc), 32'h10);
      end
      stall = 0;
      cyc(1);
      chk("hs_consumed", 32'(if_valid), 32'h0);
      redirect_valid = 1;
      redirect_target = 8'h55;
      cyc(1);
      redirect_valid = 0;
      chk("hs_rd_pc", 32'(pc_out), 32'h10);
      chk("hs_rd_halt", 32'(halted), 32'h1);

      // Async reset between edges at pc=7
      do_reset();
      cyc(7);
      chk("ar_pc0", 32'(pc_out), 32'h7);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_pc", 32'(pc_out), 32'h0);
      chk("ar_valid", 32'(if_valid), 32'h0);
      chk("ar_halt", 32'(halted), 32'h0);
      chk("ar_count", 32'(fetch_count), 32'h0);
      cyc(1);
      rst_n = 1'b1;
      cyc(3);
      chk("ar_run_pc", 32'(pc_out), 32'h3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
